// File: rtl/shared_bus_arbiter_pkg.sv
// Shared definitions for the two-source bus arbiter: FSM states, grant
// encodings and the tenure counter width.
package shared_bus_arbiter_pkg;

    localparam int TENURE_W = 8;
    localparam logic [TENURE_W-1:0] TENURE_ONE = TENURE_W'(1);

    localparam logic [1:0] GRANT_IDLE = 2'b00;
    localparam logic [1:0] GRANT_S0   = 2'b01;
    localparam logic [1:0] GRANT_S1   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GRANT0 = 2'b01,
        ST_GRANT1 = 2'b10
    } state_e;

    function automatic logic [1:0] grant_of(input state_e st);
        logic [1:0] g;
        case (st)
            ST_GRANT0: g = GRANT_S0;
            ST_GRANT1: g = GRANT_S1;
            ST_IDLE:   g = GRANT_IDLE;
            default:   g = GRANT_IDLE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/shared_bus_arbiter_if.sv
// Handshake bundle between the two sources, the arbiter and the shared bus
// consumer. The slave modport is the arbiter's view.
interface shared_bus_arbiter_if;

    logic        s0_valid;
    logic        s0_ready;
    logic [2:-2] s0_data;
    logic        s1_valid;
    logic        s1_ready;
    logic [-2:2] s1_data;
    logic        m_valid;
    logic        m_ready;
    logic [2:-2] m_data;
    logic [1:0]  grant;

    modport slave (
        input  s0_valid, s0_data, s1_valid, s1_data, m_ready,
        output s0_ready, s1_ready, m_valid, m_data, grant
    );

    modport master (
        output s0_valid, s0_data, s1_valid, s1_data, m_ready,
        input  s0_ready, s1_ready, m_valid, m_data, grant
    );

endinterface

// File: rtl/shared_bus_rr_pick.sv
// Combinational next-owner selection: round-robin from idle, hold while the
// owner streams, hand over when the owner drops or its tenure expires.
module shared_bus_rr_pick
    import shared_bus_arbiter_pkg::*;
(
    input  state_e state,
    input  logic   s0_valid,
    input  logic   s1_valid,
    input  logic   last,
    input  logic   expired,
    output state_e next_state
);

    // last == 1 means source 1 was served most recently, so source 0 wins a tie
    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE: begin
                if (s0_valid && s1_valid) begin
                    if (last) begin
                        next_state = ST_GRANT0;
                    end else begin
                        next_state = ST_GRANT1;
                    end
                end else if (s0_valid) begin
                    next_state = ST_GRANT0;
                end else if (s1_valid) begin
                    next_state = ST_GRANT1;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_GRANT0: begin
                if (s1_valid && (!s0_valid || expired)) begin
                    next_state = ST_GRANT1;
                end else if (s0_valid) begin
                    next_state = ST_GRANT0;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_GRANT1: begin
                if (s0_valid && (!s1_valid || expired)) begin
                    next_state = ST_GRANT0;
                end else if (s1_valid) begin
                    next_state = ST_GRANT1;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Two-source shared-bus arbiter with bounded grant tenure and a one-word
// registered output slot.
module shared_bus_arbiter
    import shared_bus_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 10
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    shared_bus_arbiter_if.slave  bus
);

    localparam logic [TENURE_W-1:0] HOLD_C = TENURE_W'(HOLD_MAX);

    state_e              state_r;
    state_e              state_nxt_s;
    logic [1:0]          grant_r;
    logic                last_r;
    logic [TENURE_W-1:0] tenure_r;
    logic [TENURE_W-1:0] tenure_inc_s;
    logic                m_valid_r;
    logic [2:-2]         m_data_r;
    logic                slot_free_s;
    logic                s0_ready_s;
    logic                s1_ready_s;
    logic                acc0_s;
    logic                acc1_s;
    logic                accept_s;
    logic                expired_s;

    // The output slot can take a word when empty or being drained this cycle
    assign slot_free_s = !m_valid_r || bus.m_ready;
    assign s0_ready_s  = (state_r == ST_GRANT0) && slot_free_s;
    assign s1_ready_s  = (state_r == ST_GRANT1) && slot_free_s;
    assign acc0_s      = s0_ready_s && bus.s0_valid;
    assign acc1_s      = s1_ready_s && bus.s1_valid;
    assign accept_s    = acc0_s || acc1_s;

    // Saturating tenure increment; expiry is judged on the post-acceptance value
    always_comb begin
        tenure_inc_s = tenure_r;
        if (tenure_r < HOLD_C) begin
            tenure_inc_s = tenure_r + TENURE_ONE;
        end else begin
            tenure_inc_s = tenure_r;
        end
    end

    assign expired_s = accept_s && (tenure_inc_s == HOLD_C);

    shared_bus_rr_pick u_pick (
        .state      (state_r),
        .s0_valid   (bus.s0_valid),
        .s1_valid   (bus.s1_valid),
        .last       (last_r),
        .expired    (expired_s),
        .next_state (state_nxt_s)
    );

    // FSM, tenure counter, last-served pointer and output slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            grant_r   <= GRANT_IDLE;
            last_r    <= 1'b1;
            tenure_r  <= '0;
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_of(state_nxt_s);
            if (state_nxt_s != state_r) begin
                tenure_r <= '0;
            end else if (accept_s) begin
                tenure_r <= tenure_inc_s;
            end else begin
                tenure_r <= tenure_r;
            end
            if ((state_r != ST_IDLE) && (state_nxt_s != state_r)) begin
                last_r <= (state_r == ST_GRANT1);
            end else begin
                last_r <= last_r;
            end
            // Packed assignment is positional, so s1_data[-2] lands on m_data[2]
            if (acc0_s) begin
                m_valid_r <= 1'b1;
                m_data_r  <= bus.s0_data;
            end else if (acc1_s) begin
                m_valid_r <= 1'b1;
                m_data_r  <= bus.s1_data;
            end else if (bus.m_ready) begin
                m_valid_r <= 1'b0;
            end else begin
                m_valid_r <= m_valid_r;
            end
        end
    end

    assign bus.s0_ready = s0_ready_s;
    assign bus.s1_ready = s1_ready_s;
    assign bus.m_valid  = m_valid_r;
    assign bus.m_data   = m_data_r;
    assign bus.grant    = grant_r;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter: one instance with a short tenure
// limit for handover tests, one with the default limit for a long stream.
module tb_shared_bus_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    shared_bus_arbiter_if bus_a ();
    shared_bus_arbiter_if bus_b ();

    shared_bus_arbiter #(.HOLD_MAX(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    shared_bus_arbiter dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] w0;
        logic [4:0] w1;
        logic [4:0] exp_w;
        logic [4:0] m_word;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus_a.s0_valid = 1'b0; bus_a.s0_data = 5'b00000;
        bus_a.s1_valid = 1'b0; bus_a.s1_data = 5'b00000;
        bus_a.m_ready  = 1'b0;
        bus_b.s0_valid = 1'b0; bus_b.s0_data = 5'b00000;
        bus_b.s1_valid = 1'b0; bus_b.s1_data = 5'b00000;
        bus_b.m_ready  = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_grant",    32'(bus_a.grant),    32'd0);
        chk("rst_m_valid",  32'(bus_a.m_valid),  32'd0);
        chk("rst_m_data",   32'(bus_a.m_data),   32'd0);
        chk("rst_s0_ready", 32'(bus_a.s0_ready), 32'd0);
        chk("rst_s1_ready", 32'(bus_a.s1_ready), 32'd0);
        chk("rst_tenure",   32'(dut_a.tenure_r), 32'd0);

        // Single source 0 transfer
        rst_n = 1'b1;
        bus_a.s0_valid = 1'b1; bus_a.s0_data = 5'b10110; bus_a.m_ready = 1'b1;
        step();
        chk("s0_grant",    32'(bus_a.grant),    32'd1);
        chk("s0_ready",    32'(bus_a.s0_ready), 32'd1);
        chk("s0_s1_ready", 32'(bus_a.s1_ready), 32'd0);
        chk("s0_lat_mv",   32'(bus_a.m_valid),  32'd0);
        step();
        chk("s0_m_valid", 32'(bus_a.m_valid), 32'd1);
        chk("s0_m_data",  32'(bus_a.m_data),  32'h16);
        bus_a.s0_valid = 1'b0;
        step();
        chk("s0_idle_grant", 32'(bus_a.grant),   32'd0);
        chk("s0_drain_mv",   32'(bus_a.m_valid), 32'd0);

        // Source 1 positional mapping: s1_data[-2] drives m_data[2]
        bus_a.s1_valid = 1'b1; bus_a.s1_data = 5'b10000;
        step();
        chk("s1_grant", 32'(bus_a.grant),    32'd2);
        chk("s1_ready", 32'(bus_a.s1_ready), 32'd1);
        bus_a.s1_data = 5'b10000;
        step();
        m_word = bus_a.m_data;
        chk("s1_msb",    32'(bus_a.m_data[2]),  32'd1);
        chk("s1_low",    32'(m_word[3:0]),      32'd0);
        bus_a.s1_data = 5'b11010;
        step();
        chk("s1_asym", 32'(bus_a.m_data), 32'h1A);
        bus_a.s1_valid = 1'b0;
        step();
        chk("s1_idle", 32'(bus_a.grant), 32'd0);

        // Both valid, HOLD_MAX=3: 0,0,0,1,1,1,0,0,0 with no bubble
        w0 = 5'b00011; w1 = 5'b11100;
        bus_a.s0_valid = 1'b1; bus_a.s0_data = w0;
        bus_a.s1_valid = 1'b1; bus_a.s1_data = w1;
        step();
        chk("rr_first_grant", 32'(bus_a.grant), 32'd1);
        for (int i = 0; i < 9; i++) begin
            step();
            exp_w = (((i / 3) % 2) == 1) ? w1 : w0;
            chk($sformatf("rr_data_%0d", i),  32'(bus_a.m_data),  32'(exp_w));
            chk($sformatf("rr_valid_%0d", i), 32'(bus_a.m_valid), 32'd1);
            chk($sformatf("rr_grant_%0d", i), 32'(bus_a.grant),
                ((((i + 1) / 3) % 2) == 1) ? 32'd2 : 32'd1);
        end
        bus_a.s0_valid = 1'b0; bus_a.s1_valid = 1'b0;
        step();
        chk("rr_end_grant", 32'(bus_a.grant),   32'd0);
        chk("rr_end_mv",    32'(bus_a.m_valid), 32'd0);

        // Backpressure keeps the grant and freezes the tenure
        bus_a.s0_valid = 1'b1; bus_a.s0_data = 5'b01010;
        step();
        step();
        chk("bp_first_data", 32'(bus_a.m_data),   32'h0A);
        chk("bp_tenure0",    32'(dut_a.tenure_r), 32'd1);
        bus_a.m_ready = 1'b0; bus_a.s0_data = 5'b00101;
        #1;
        chk("bp_ready_low", 32'(bus_a.s0_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("bp_ready_%0d", i),  32'(bus_a.s0_ready), 32'd0);
            chk($sformatf("bp_data_%0d", i),   32'(bus_a.m_data),   32'h0A);
            chk($sformatf("bp_grant_%0d", i),  32'(bus_a.grant),    32'd1);
            chk($sformatf("bp_tenure_%0d", i), 32'(dut_a.tenure_r), 32'd1);
        end
        bus_a.m_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus_a.s0_ready), 32'd1);
        step();
        chk("bp_resume_data",   32'(bus_a.m_data),   32'h05);
        chk("bp_resume_tenure", 32'(dut_a.tenure_r), 32'd2);
        bus_a.s0_valid = 1'b0;
        step();
        chk("bp_idle", 32'(bus_a.grant), 32'd0);

        // Lone source 1 streams 20 words past HOLD_MAX=10
        bus_b.s1_valid = 1'b1; bus_b.m_ready = 1'b1; bus_b.s1_data = 5'd0;
        step();
        chk("lone_grant0", 32'(bus_b.grant), 32'd2);
        for (int i = 0; i < 20; i++) begin
            bus_b.s1_data = 5'(i + 3);
            step();
            chk($sformatf("lone_grant_%0d", i), 32'(bus_b.grant),  32'd2);
            chk($sformatf("lone_data_%0d", i),  32'(bus_b.m_data), 32'(i + 3));
        end
        chk("lone_tenure", 32'(dut_b.tenure_r), 32'd10);
        bus_b.s1_valid = 1'b0;
        step();
        chk("lone_idle", 32'(bus_b.grant), 32'd0);

        // Reset mid-tenure with a held word, then a tie goes to source 0
        bus_a.s1_valid = 1'b1; bus_a.s1_data = 5'b01111;
        step();
        chk("mr_grant", 32'(bus_a.grant), 32'd2);
        step();
        chk("mr_mv_pre", 32'(bus_a.m_valid), 32'd1);
        rst_n = 1'b0;
        bus_a.s0_valid = 1'b1; bus_a.s0_data = 5'b10001;
        step();
        chk("mr_mv",     32'(bus_a.m_valid),  32'd0);
        chk("mr_grant0", 32'(bus_a.grant),    32'd0);
        chk("mr_data",   32'(bus_a.m_data),   32'd0);
        chk("mr_tenure", 32'(dut_a.tenure_r), 32'd0);
        rst_n = 1'b1;
        step();
        chk("mr_first_grant", 32'(bus_a.grant), 32'd1);
        step();
        chk("mr_first_data", 32'(bus_a.m_data), 32'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shared_bus_arbiter.md
SHARED_BUS_ARBITER -- requirements
Module: shared_bus_arbiter

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-low reset, rst_n; all state SHALL update on the rising edge of clk only.
REQ-002 Parameter HOLD_MAX, default 10: the maximum number of accepted transfers per grant tenure while the other source is waiting; legal range is 1..255.
REQ-003 Port clk, input, 1 bit: the clock.
REQ-004 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-005 Port s0_valid, input, 1 bit: source 0 offers a word.
REQ-006 Port s0_ready, output, 1 bit: source 0 word accepted this cycle when s0_valid is also high.
REQ-007 Port s0_data, input, range [2:-2]: source 0 word (descending range).
REQ-008 Port s1_valid, input, 1 bit: source 1 offers a word.
REQ-009 Port s1_ready, output, 1 bit: source 1 accept.
REQ-010 Port s1_data, input, range [-2:2]: source 1 word (ascending range).
REQ-011 Port m_valid, output, 1 bit: the shared bus holds a word.
REQ-012 Port m_ready, input, 1 bit: the consumer takes the word.
REQ-013 Port m_data, output, range [2:-2]: shared bus word.
REQ-014 Port grant, output, 2 bits: one-hot current owner (bit0 = source 0, bit1 = source 1); 2'b00 means idle.

Function
REQ-015 States SHALL be IDLE, GRANT0 and GRANT1; grant SHALL equal 00, 01 and 10 in those states respectively.
REQ-016 In IDLE, if exactly one source is valid, that source SHALL be granted at the next edge; if both are valid, the source not served last SHALL be granted; a last-served pointer of 1 after reset means source 0 wins first.
REQ-017 sx_ready SHALL be high only in GRANTx and only when (!m_valid || m_ready); the other source's ready SHALL be low.
REQ-018 Each accepted transfer SHALL load m_data and set m_valid at the next edge, giving a latency of 1 cycle from acceptance to m_valid.
REQ-019 m_valid SHALL clear at an edge where m_valid && m_ready holds and no new acceptance occurs; a simultaneous drain and accept SHALL keep m_valid high with the new word.
REQ-020 The m_data mapping SHALL be positional, MSB-first with no bit reversal: from source 0, m_data[k] = s0_data[k]; from source 1, m_data[2..-2] = s1_data[-2..2], so s1_data[-2] drives m_data[2].
REQ-021 An 8-bit tenure counter SHALL clear on every grant change and increment on each acceptance, saturating at HOLD_MAX.
REQ-022 Leaving GRANTx when the other source is valid SHALL occur when sx_valid is low in the current cycle, or when this cycle's acceptance makes the tenure reach HOLD_MAX; the next state SHALL be GRANT(other).
REQ-023 Leaving GRANTx when the other source is not valid SHALL go to IDLE if sx_valid is low, and otherwise SHALL remain in GRANTx past HOLD_MAX with the counter saturated.
REQ-024 A source backpressured by !m_ready SHALL keep its grant; the tenure counter SHALL count only actual acceptances.
REQ-025 The last-served pointer SHALL update on every exit from GRANTx to x.
REQ-026 No word SHALL be dropped or duplicated; sx_data is sampled only on an acceptance cycle.

Reset
REQ-027 While rst_n is low at an edge, the block SHALL enter IDLE with grant=00, m_valid=0, m_data=0, s0_ready=s1_ready=0, tenure=0 and last-served pointer=1.
REQ-028 A reset asserted mid-tenure or with m_valid high SHALL discard the held word; the first grant after reset SHALL follow REQ-016.

Structure
REQ-029 Package shared_bus_arbiter_pkg SHALL hold the state enumeration, the grant encodings and the tenure counter width constant (8).
REQ-030 One sub-module, shared_bus_rr_pick, SHALL implement the combinational next-owner selection from the valids, the last-served pointer and the tenure-expired flag; the FSM, counter and output register SHALL stay in the top level.

Verification
REQ-031 Reset, then s0_valid=1 with s0_data=5'b10110 and m_ready=1: grant=01 after 1 edge, s0_ready high, m_data=10110 with m_valid=1 one edge after acceptance.
REQ-032 s1_data[-2:2]=5'b10000 accepted: m_data[2]=1 and m_data[1:-2]=0.
REQ-033 Both sources valid continuously, HOLD_MAX=3, m_ready=1: bus sources follow the pattern 0,0,0,1,1,1,0,... with no idle cycle at switches.
REQ-034 GRANT0 with m_ready=0 for 4 cycles: s0_ready=0, m_data stable, grant stays 01, tenure unchanged; on release the transfer resumes.
REQ-035 Only s1 valid for 20 transfers with HOLD_MAX=10: grant stays 10 throughout and the tenure counter reads 10.
REQ-036 rst_n low for one edge while m_valid=1 mid-tenure: m_valid=0 and grant=00 next cycle; with both sources valid afterwards, source 0 is granted first.
